gray_async_fifo: RTL and testbench

GRAY_ASYNC_FIFO -- requirements
Module: gray_async_fifo

---
 rtl/gray_async_fifo_if.sv | 32 +++
 rtl/gray_async_fifo.sv | 109 ++++++++++
 tb/tb_gray_async_fifo.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gray_async_fifo_if.sv
// Bundle of write-side and read-side signals for gray_async_fifo.
// Handshake: wr_en is valid and !full is ready, so a word moves on a wr_clk edge where both are high.
// The same rule applies to rd_en and !empty on rd_clk.
interface gray_async_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wr_level;
  logic              overflow;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_level;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, wr_level, overflow,
    input  rd_data, empty, almost_empty, rd_level, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, wr_level, overflow,
    output rd_data, empty, almost_empty, rd_level, underflow
  );
endinterface

// File: rtl/gray_async_fifo.sv
// Dual-clock FIFO. Gray-coded pointers cross between the clock domains through 2-flop synchronisers.
// Flags are registered and only ever pessimistic.
module gray_async_fifo #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input logic               wr_clk,
  input logic               rd_clk,
  input logic               rst,
  gray_async_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset asserts at once but is released separately in each domain, on that domain's own clock.
  logic [1:0] wr_rst_q, rd_rst_q;
  logic       wr_rst, rd_rst;

  always_ff @(posedge wr_clk or posedge rst)
    if (rst) wr_rst_q <= 2'b11;
    else     wr_rst_q <= {wr_rst_q[0], 1'b0};

  always_ff @(posedge rd_clk or posedge rst)
    if (rst) rd_rst_q <= 2'b11;
    else     rd_rst_q <= {rd_rst_q[0], 1'b0};

  assign wr_rst = wr_rst_q[1];
  assign rd_rst = rd_rst_q[1];

  // ---------------- write domain ----------------
  logic [PW-1:0] wbin, wgray, wbin_next, wgray_next;
  logic [PW-1:0] rq1_gray, rq2_gray, wr_level_next;
  logic          wr_accept, full_next;

  assign wr_accept     = bus.wr_en && !bus.full && !wr_rst;
  assign wbin_next     = wbin + PW'(wr_accept);
  assign wgray_next    = wbin_next ^ (wbin_next >> 1);
  assign full_next     = (wgray_next == {~rq2_gray[PW-1:PW-2], rq2_gray[PW-3:0]});
  assign wr_level_next = wbin_next - gray2bin(rq2_gray);

  always_ff @(posedge wr_clk)
    if (wr_accept) mem[wbin[ADDR_W-1:0]] <= bus.wr_data;

  always_ff @(posedge wr_clk or posedge wr_rst)
    if (wr_rst) begin
      wbin            <= '0;
      wgray           <= '0;
      rq1_gray        <= '0;
      rq2_gray        <= '0;
      bus.full        <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.wr_level    <= '0;
      bus.overflow    <= 1'b0;
    end else begin
      wbin            <= wbin_next;
      wgray           <= wgray_next;
      rq1_gray        <= rgray;
      rq2_gray        <= rq1_gray;
      bus.full        <= full_next;
      bus.almost_full <= (wr_level_next >= PW'(AF_LEVEL));
      bus.wr_level    <= wr_level_next;
      bus.overflow    <= bus.wr_en && bus.full;
    end

  // ---------------- read domain ----------------
  logic [PW-1:0] rbin, rgray, rbin_next, rgray_next;
  logic [PW-1:0] wq1_gray, wq2_gray, rd_level_next;
  logic          rd_accept, empty_next;

  assign rd_accept     = bus.rd_en && !bus.empty && !rd_rst;
  assign rbin_next     = rbin + PW'(rd_accept);
  assign rgray_next    = rbin_next ^ (rbin_next >> 1);
  assign empty_next    = (rgray_next == wq2_gray);
  assign rd_level_next = gray2bin(wq2_gray) - rbin_next;

  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      rbin             <= '0;
      rgray            <= '0;
      wq1_gray         <= '0;
      wq2_gray         <= '0;
      bus.rd_data      <= '0;
      bus.empty        <= 1'b1;
      bus.almost_empty <= 1'b1;
      bus.rd_level     <= '0;
      bus.underflow    <= 1'b0;
    end else begin
      rbin             <= rbin_next;
      rgray            <= rgray_next;
      wq1_gray         <= wgray;
      wq2_gray         <= wq1_gray;
      if (rd_accept) bus.rd_data <= mem[rbin[ADDR_W-1:0]];
      bus.empty        <= empty_next;
      bus.almost_empty <= (rd_level_next <= PW'(AE_LEVEL));
      bus.rd_level     <= rd_level_next;
      bus.underflow    <= bus.rd_en && bus.empty;
    end
endmodule

// File: tb/tb_gray_async_fifo.sv
// Directed and streamed checks of gray_async_fifo at default parameters.
`timescale 1ns/1ps
module tb_gray_async_fifo;
  logic    wr_clk = 1'b0;
  logic    rd_clk = 1'b0;
  logic    rst    = 1'b1;
  realtime wr_half = 5.0;
  realtime rd_half = 13.5;
  int      checks = 0;
  int      errors = 0;
  logic [31:0] exp_q[$];

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  gray_async_fifo_if #(.DATA_W(32), .ADDR_W(3)) bus();

  gray_async_fifo #(.DATA_W(32), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .wr_clk (wr_clk),
    .rd_clk (rd_clk),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word(input logic [31:0] d);
    @(negedge wr_clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge wr_clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd_word(output logic [31:0] d);
    @(negedge rd_clk);
    bus.rd_en = 1'b1;
    @(negedge rd_clk);
    bus.rd_en = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic run_stream(input int n, input string tag);
    int bad = 0;
    fork
      begin : writer
        int sent = 0;
        logic [31:0] wd;
        while (sent < n) begin
          @(negedge wr_clk);
          if (bus.overflow !== 1'b0 || bus.wr_level > 4'd8) bad++;
          if (!bus.full && $urandom_range(0, 1) == 1) begin
            wd = $urandom;
            bus.wr_en   = 1'b1;
            bus.wr_data = wd;
            exp_q.push_back(wd);
            sent++;
          end else begin
            bus.wr_en = 1'b0;
          end
        end
        @(negedge wr_clk);
        bus.wr_en = 1'b0;
      end
      begin : reader
        int   got = 0;
        int   cyc = 0;
        logic pend = 1'b0;
        logic [31:0] ev;
        while (got < n && cyc < 20000) begin
          @(negedge rd_clk);
          cyc++;
          if (bus.underflow !== 1'b0 || bus.rd_level > 4'd8) bad++;
          if (pend) begin
            if (exp_q.size() == 0) begin
              chk({tag, "_extra_read"}, bus.rd_data, 32'hx);
            end else begin
              ev = exp_q.pop_front();
              chk({tag, "_data"}, bus.rd_data, ev);
            end
            got++;
          end
          pend = !bus.empty && ($urandom_range(0, 1) == 1);
          bus.rd_en = pend;
        end
        bus.rd_en = 1'b0;
        chk({tag, "_read_count"}, got, n);
      end
    join
    chk({tag, "_flags_levels"}, bad, 0);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] d;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    // Reset state
    #23;
    chk("rst_empty", bus.empty, 1);
    chk("rst_almost_empty", bus.almost_empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_almost_full", bus.almost_full, 0);
    chk("rst_wr_level", bus.wr_level, 0);
    chk("rst_rd_level", bus.rd_level, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_underflow", bus.underflow, 0);
    rst = 1'b0;
    repeat (4) @(negedge rd_clk);

    // Fill with 1..8, checking cross-domain empty latency and threshold
    wr_word(32'd1);
    repeat (3) @(posedge rd_clk);
    #1;
    chk("empty_deassert_3_rd_edges", bus.empty, 0);
    chk("wr_level_after_1", bus.wr_level, 1);
    for (int i = 2; i <= 8; i++) begin
      wr_word(i);
      if (i == 5) chk("almost_full_at_5", bus.almost_full, 0);
      if (i == 6) chk("almost_full_at_6", bus.almost_full, 1);
    end
    chk("full_after_8", bus.full, 1);
    chk("wr_level_full", bus.wr_level, 8);

    // Three refused writes
    @(negedge wr_clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge wr_clk);
      chk("overflow_pulse", bus.overflow, 1);
      chk("full_held", bus.full, 1);
    end
    bus.wr_en = 1'b0;
    @(negedge wr_clk);
    chk("overflow_clear", bus.overflow, 0);

    repeat (4) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("rd_level_full", bus.rd_level, 8);
    chk("almost_empty_full", bus.almost_empty, 0);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      rd_word(d);
      chk("read_order", d, i);
      if (i == 1) begin
        repeat (3) @(posedge wr_clk);
        @(negedge wr_clk);
        chk("full_deassert", bus.full, 0);
        chk("wr_level_after_read", bus.wr_level, 7);
      end
      if (i == 5) chk("almost_empty_at_3", bus.almost_empty, 0);
      if (i == 6) chk("almost_empty_at_2", bus.almost_empty, 1);
    end
    chk("empty_after_drain", bus.empty, 1);
    chk("rd_level_drained", bus.rd_level, 0);

    // Two refused reads
    @(negedge rd_clk);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge rd_clk);
      chk("underflow_pulse", bus.underflow, 1);
      chk("rd_data_held", bus.rd_data, 8);
    end
    bus.rd_en = 1'b0;
    @(negedge rd_clk);
    chk("underflow_clear", bus.underflow, 0);
    chk("rd_level_underflow", bus.rd_level, 0);

    // Mid-operation reset discards stored words
    for (int i = 0; i < 5; i++) wr_word(32'h10 + i);
    repeat (4) @(posedge rd_clk);
    @(negedge rd_clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_full", bus.full, 0);
    chk("midrst_wr_level", bus.wr_level, 0);
    chk("midrst_rd_level", bus.rd_level, 0);
    chk("midrst_almost_empty", bus.almost_empty, 1);
    repeat (3) @(negedge wr_clk);
    rst = 1'b0;
    repeat (4) @(negedge rd_clk);
    chk("postrst_empty", bus.empty, 1);
    wr_word(32'hA5A5_A5A5);
    repeat (3) @(posedge rd_clk);
    #1;
    chk("postrst_not_empty", bus.empty, 0);
    rd_word(d);
    chk("postrst_first_word", d, 32'hA5A5_A5A5);
    chk("postrst_empty_again", bus.empty, 1);

    // Random streams at 3:1 and 1:3 clock ratios
    wr_half = 5.0;
    rd_half = 15.0;
    repeat (4) @(negedge rd_clk);
    run_stream(500, "wr_fast");
    wr_half = 15.0;
    rd_half = 5.0;
    repeat (4) @(negedge wr_clk);
    run_stream(500, "rd_fast");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
